instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage that drives the instruction memory address and latches the returned 16-bit instruction into an IF/ID register for the decoder.
- Owns the program counter (PC). Handles sequential increment, decoder/branch-unit redirects, pipeline stalls and halt.
- The instruction memory is combinational: data for imem_addr_o is valid in the same cycle.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded at reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_addr_o  output  ADDR_W  address to instruction memory; always equals the PC register
- imem_data_i  input  INSTR_W  instruction returned for imem_addr_o (same cycle)
- stall_i  input  1  downstream not ready; hold PC and IF/ID
- redirect_i  input  1  branch/jump taken; load redirect_pc_i
- redirect_pc_i  input  ADDR_W  redirect target
- halt_i  input  1  halt request from decode
- ir_o  output  INSTR_W  IF/ID instruction register
- ir_pc_o  output  ADDR_W  PC of the instruction in ir_o
- ir_valid_o  output  1  ir_o holds a real instruction
- halted_o  output  1  block is in HALTED
- fetch_count_o  output  16  number of instructions latched valid; saturating

Behaviour:
- Reset (async, rst_n=0), all outputs take these values immediately:
  - pc=RESET_PC, ir_o=NOP (16'h0000), ir_pc_o=0, ir_valid_o=0, halted_o=0, fetch_count_o=0, state=RUN.
- States: RUN, HALTED. Per-edge priority in RUN: halt_i > redirect_i > stall_i > normal fetch.
- RUN, normal fetch (no halt/redirect/stall):
  - ir_o<=imem_data_i, ir_pc_o<=pc, ir_valid_o<=1, pc<=pc+1.
  - Latency: one edge from address to ir_o.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 wraps to 16'h0000, with no flag.
- RUN, stall_i=1 (no redirect/halt): pc, ir_o, ir_pc_o, ir_valid_o and fetch_count_o all hold.
- RUN, redirect_i=1 (no halt):
  - pc<=redirect_pc_i; ir_o<=NOP; ir_valid_o<=0 (flush of wrong-path instruction).
  - Overrides a simultaneous stall_i.
  - The first target instruction appears on ir_o one edge later, provided that cycle is not stalled.
  - Redirect to the current pc is legal and behaves identically.
- RUN, halt_i=1:
  - state<=HALTED; ir_valid_o<=0; ir_o<=NOP; pc holds.
  - A simultaneous redirect/stall is ignored.
- HALTED:
  - halted_o=1 (registered, asserted from the edge that enters HALTED).
  - pc, ir_o, ir_pc_o and fetch_count_o hold; ir_valid_o=0.
  - stall_i, redirect_i and halt_i are ignored. Exit only via reset.
- fetch_count_o increments on every edge that sets ir_valid_o<=1 from a fetch. It saturates at 16'hFFFF and does not wrap.
- Reset mid-operation, including mid-stall or in HALTED: returns immediately to reset values. Fetch from RESET_PC begins on the first edge after rst_n deasserts.
- imem_addr_o is combinational from the pc register only, never from inputs, so there is no combinational path from input to imem_addr_o.
- No X propagation: imem_data_i is captured only in the normal-fetch case.

Decomposition:
- Shared package contains:
  - ADDR_W and INSTR_W constants.
  - NOP encoding 16'h0000.
  - fetch-state enum {RUN, HALTED}.
  - The decoder and branch unit reuse these.
- One natural sub-module, fetch_pc: PC register, next-PC mux (pc+1 / redirect / hold) and wrap arithmetic.
- The IF/ID register, state machine and counter stay in the top.

Test Plan:
- Reset, then 5 free-running cycles, with the memory model returning data=addr^16'hA5A5 -> ir_o sequence 16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6, 16'hA5A1; ir_pc_o=0..4; fetch_count_o=5.
- Stall for 3 cycles at pc=3 -> ir_o, ir_pc_o=2 and imem_addr_o=3 are frozen. On release, ir_pc_o=3 on the next edge and the count resumes without a gap.
- redirect_i with target 16'h0010 asserted together with stall_i at pc=7:
  - next edge: ir_valid_o=0, imem_addr_o=16'h0010;
  - following edge: ir_pc_o=16'h0010, ir_valid_o=1.
- Redirect to 16'hFFFE, run 3 cycles -> ir_pc_o=FFFE, FFFF, 0000 (wrap); imem_addr_o=0001.
- halt_i together with redirect_i at pc=9:
  - -> halted_o=1, pc stays at 9, ir_valid_o=0.
  - 10 further cycles of redirect/stall toggling cause no change.
  - Async rst_n pulse mid-cycle -> outputs return to reset values before the next edge.
- Force fetch_count_o to 16'hFFFE via long run or preload, then fetch 3 -> value remains 16'hFFFF.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, NOP encoding and fetch states.
// Imported by the fetch stage, and later by the decoder and branch unit.
package instruction_fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // The counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: instruction-memory bus, control from decode/branch,
// and the IF/ID register outputs. "slave" is the fetch stage's view.
interface instruction_fetch_if #(
    parameter int ADDR_W  = instruction_fetch_pkg::ADDR_W,
    parameter int INSTR_W = instruction_fetch_pkg::INSTR_W
);

    logic [ADDR_W-1:0]                      imem_addr_o;
    logic [INSTR_W-1:0]                     imem_data_i;
    logic                                   stall_i;
    logic                                   redirect_i;
    logic [ADDR_W-1:0]                      redirect_pc_i;
    logic                                   halt_i;
    logic [INSTR_W-1:0]                     ir_o;
    logic [ADDR_W-1:0]                      ir_pc_o;
    logic                                   ir_valid_o;
    logic                                   halted_o;
    logic [instruction_fetch_pkg::CNT_W-1:0] fetch_count_o;

    modport slave (
        output imem_addr_o,
        input  imem_data_i,
        input  stall_i,
        input  redirect_i,
        input  redirect_pc_i,
        input  halt_i,
        output ir_o,
        output ir_pc_o,
        output ir_valid_o,
        output halted_o,
        output fetch_count_o
    );

    modport master (
        input  imem_addr_o,
        output imem_data_i,
        output stall_i,
        output redirect_i,
        output redirect_pc_i,
        output halt_i,
        input  ir_o,
        input  ir_pc_o,
        input  ir_valid_o,
        input  halted_o,
        input  fetch_count_o
    );

endinterface

// File: rtl/instruction_fetch_fetch_pc.sv
// Program counter: register plus next-PC select (redirect / pc+1 / hold).
// Increment wraps modulo 2^ADDR_W with no overflow indication.
module instruction_fetch_fetch_pc #(
    parameter int                ADDR_W   = instruction_fetch_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the combinational instruction memory from the PC and
// captures the returned word into the IF/ID register; owns RUN/HALTED state.
module instruction_fetch #(
    parameter int                ADDR_W   = instruction_fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = instruction_fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.slave   bus
);

    import instruction_fetch_pkg::*;

    localparam logic [0:0] S_RUN    = RUN;
    localparam logic [0:0] S_HALTED = HALTED;

    logic [0:0]         state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

    logic [ADDR_W-1:0]  pc;
    logic               pc_redirect;
    logic               pc_advance;

    instruction_fetch_fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (pc_redirect),
        .redirect_pc_i (bus.redirect_pc_i),
        .advance_i     (pc_advance),
        .pc_o          (pc)
    );

    // Priority in RUN: halt, then redirect, then stall, then a normal fetch.
    // imem_data_i is only sampled on the normal-fetch path.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        fetch_count_d = fetch_count_q;
        pc_redirect   = 1'b0;
        pc_advance    = 1'b0;

        case (state_q)
            S_RUN: begin
                if (bus.halt_i) begin
                    state_d    = S_HALTED;
                    ir_d       = NOP;
                    ir_valid_d = 1'b0;
                end else if (bus.redirect_i) begin
                    pc_redirect = 1'b1;
                    ir_d        = NOP;
                    ir_valid_d  = 1'b0;
                end else if (!bus.stall_i) begin
                    pc_advance    = 1'b1;
                    ir_d          = bus.imem_data_i;
                    ir_pc_d       = pc;
                    ir_valid_d    = 1'b1;
                    fetch_count_d = sat_inc(fetch_count_q);
                end
            end
            default: begin
                ir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            ir_q          <= NOP;
            ir_pc_q       <= '0;
            ir_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr_o   = pc;
    assign bus.ir_o          = ir_q;
    assign bus.ir_pc_o       = ir_pc_q;
    assign bus.ir_valid_o    = ir_valid_q;
    assign bus.halted_o      = (state_q == S_HALTED);
    assign bus.fetch_count_o = fetch_count_q;

endmodule
